// File: rtl/dshot_bidir_tlm_rx.sv
// dshot_bidir_tlm_rx: bidirectional-DSHOT eRPM telemetry receiver.
// After the transmitter releases the pad, this block waits out the turnaround
// blank and catches the ESC's start edge. It then samples the 21-bit GCR reply,
// re-aligning its bit clock on every line edge. Finally it decodes the reply
// and reports the eRPM period in microseconds.
`timescale 1ns/1ps
module dshot_bidir_tlm_rx #(
  parameter int BIT_CLKS     = 96,
  parameter int BLANK_CLKS   = 1440,
  parameter int TIMEOUT_CLKS = 7200
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        rx_i,
  input  logic        arm_i,
  output logic        busy_o,
  output logic        tlm_valid_o,
  output logic [15:0] tlm_raw_o,
  output logic [15:0] tlm_period_o,
  output logic        tlm_err_o,
  output logic        tlm_timeout_o
);

  localparam int WIN_W   = $clog2(TIMEOUT_CLKS);
  localparam int PH_W    = $clog2(BIT_CLKS);
  localparam int RUN_MAX = 6 * BIT_CLKS;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);

  localparam logic [WIN_W-1:0] WIN_BLANK = WIN_W'(BLANK_CLKS);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(TIMEOUT_CLKS - 1);
  localparam logic [PH_W-1:0]  PH_MID    = PH_W'(BIT_CLKS / 2 - 1);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(BIT_CLKS - 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(RUN_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_SAMPLE,
    S_DECODE,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic             rx_m, rx_s, rx_d;
  logic             edge_det, fall;
  logic [WIN_W-1:0] win_cnt;
  logic [PH_W-1:0]  phase;
  logic [4:0]       bit_idx;
  logic [RUN_W-1:0] run_cnt;
  logic [20:0]      raw;
  logic             frame_ok;

  logic             clr_win, start, do_sample;

  logic [19:0]      gcr;
  logic [4:0]       q3, q2, q1, q0;
  logic [15:0]      dec_word;
  logic             dec_ok;

  // Map a GCR quintet to {valid, nibble}; unknown codes come back with valid=0.
  function automatic logic [4:0] gcr_nibble(input logic [4:0] q);
    logic [4:0] r;
    r = 5'h00;
    case (q)
      5'h19: r = 5'h10;
      5'h1B: r = 5'h11;
      5'h12: r = 5'h12;
      5'h13: r = 5'h13;
      5'h1D: r = 5'h14;
      5'h15: r = 5'h15;
      5'h16: r = 5'h16;
      5'h17: r = 5'h17;
      5'h1A: r = 5'h18;
      5'h09: r = 5'h19;
      5'h0A: r = 5'h1A;
      5'h0B: r = 5'h1B;
      5'h1E: r = 5'h1C;
      5'h0D: r = 5'h1D;
      5'h0E: r = 5'h1E;
      5'h0F: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  assign edge_det = rx_s ^ rx_d;
  assign fall     = rx_d & ~rx_s;
  assign busy_o   = (state != S_IDLE);

  // Two-flop synchronizer plus a delay flop for edge detection; the line idles high.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic, datapath strobes and the one-cycle status pulses.
  always_comb begin
    state_nxt     = state;
    clr_win       = 1'b0;
    start         = 1'b0;
    do_sample     = 1'b0;
    tlm_valid_o   = 1'b0;
    tlm_err_o     = 1'b0;
    tlm_timeout_o = 1'b0;
    case (state)
      S_IDLE: begin
        if (arm_i) begin
          clr_win   = 1'b1;
          state_nxt = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        if (arm_i) begin
          clr_win = 1'b1;
        end else if (win_cnt >= WIN_BLANK && fall) begin
          start     = 1'b1;
          state_nxt = S_SAMPLE;
        end else if (win_cnt == WIN_LAST) begin
          tlm_timeout_o = 1'b1;
          state_nxt     = S_IDLE;
        end
      end
      S_SAMPLE: begin
        if (!edge_det && run_cnt == RUN_LIMIT) begin
          tlm_err_o = 1'b1;
          state_nxt = S_IDLE;
        end else if (phase == PH_MID) begin
          do_sample = 1'b1;
          if (bit_idx == 5'd20) state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        state_nxt = S_DONE;
      end
      S_DONE: begin
        tlm_valid_o = frame_ok;
        tlm_err_o   = ~frame_ok;
        state_nxt   = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (wb_rst_i) begin
      tlm_valid_o   = 1'b0;
      tlm_err_o     = 1'b0;
      tlm_timeout_o = 1'b0;
    end
  end

  // Listen-window counter: cleared on arm, counts while waiting for the start edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)                  win_cnt <= '0;
    else if (clr_win)              win_cnt <= '0;
    else if (state == S_WAIT_START) win_cnt <= win_cnt + 1'b1;
  end

  // Bit-clock recovery and shift register: any edge re-centres the sample point.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      phase   <= '0;
      bit_idx <= '0;
      run_cnt <= '0;
      raw     <= '0;
    end else if (start) begin
      phase   <= '0;
      bit_idx <= '0;
      run_cnt <= '0;
    end else if (state == S_SAMPLE) begin
      if (edge_det || phase == PH_LAST) phase <= '0;
      else                              phase <= phase + 1'b1;
      if (edge_det) run_cnt <= '0;
      else          run_cnt <= run_cnt + 1'b1;
      if (do_sample) begin
        raw     <= {raw[19:0], rx_s};
        bit_idx <= bit_idx + 5'd1;
      end
    end
  end

  // Undo the transition coding, look up each quintet and verify the checksum.
  always_comb begin
    gcr      = raw[20:1] ^ raw[19:0];
    q3       = gcr_nibble(gcr[19:15]);
    q2       = gcr_nibble(gcr[14:10]);
    q1       = gcr_nibble(gcr[9:5]);
    q0       = gcr_nibble(gcr[4:0]);
    dec_word = {q3[3:0], q2[3:0], q1[3:0], q0[3:0]};
    dec_ok   = q3[4] & q2[4] & q1[4] & q0[4] & ~raw[20] &
               ((q3[3:0] ^ q2[3:0] ^ q1[3:0] ^ q0[3:0]) == 4'hF);
  end

  // Result registers: only a clean frame replaces the held word and period.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      frame_ok     <= 1'b0;
      tlm_raw_o    <= '0;
      tlm_period_o <= '0;
    end else if (state == S_DECODE) begin
      frame_ok <= dec_ok;
      if (dec_ok) begin
        tlm_raw_o    <= dec_word;
        tlm_period_o <= {7'b0, dec_word[12:4]} << dec_word[15:13];
      end
    end
  end

endmodule

// File: tb/tb_dshot_bidir_tlm_rx.sv
// tb_dshot_bidir_tlm_rx: scoreboard bench for the DSHOT telemetry receiver.
// Each test pushes the result it expects, drives the pad, and checks the
// pulses recorded by the output monitor against the expectations.
`timescale 1ns/1ps
module tb_dshot_bidir_tlm_rx;

  localparam int BIT_CLKS     = 96;
  localparam int BLANK_CLKS   = 1440;
  localparam int TIMEOUT_CLKS = 7200;
  localparam int START_DLY    = 2160;
  localparam int ECHO_DLY     = 360;
  localparam int IDLE_110US   = 7920;
  localparam int LAT          = 3 + BIT_CLKS / 2 + 20 * BIT_CLKS + 1;

  localparam logic [2:0] K_VALID = 3'b001;
  localparam logic [2:0] K_ERR   = 3'b010;
  localparam logic [2:0] K_TO    = 3'b100;

  typedef struct {
    logic [2:0]  kind;
    logic [15:0] raw;
    logic [15:0] period;
  } exp_t;

  typedef struct {
    logic [2:0]  kind;
    logic [15:0] raw;
    logic [15:0] period;
    int          cyc;
  } obs_t;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        rx_i = 1'b1;
  logic        arm_i = 1'b0;
  logic        busy_o, tlm_valid_o, tlm_err_o, tlm_timeout_o;
  logic [15:0] tlm_raw_o, tlm_period_o;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  obs_t obs_q[$];
  obs_t mon_o;

  dshot_bidir_tlm_rx #(
    .BIT_CLKS(BIT_CLKS),
    .BLANK_CLKS(BLANK_CLKS),
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(wb_rst_i),
    .rx_i(rx_i),
    .arm_i(arm_i),
    .busy_o(busy_o),
    .tlm_valid_o(tlm_valid_o),
    .tlm_raw_o(tlm_raw_o),
    .tlm_period_o(tlm_period_o),
    .tlm_err_o(tlm_err_o),
    .tlm_timeout_o(tlm_timeout_o)
  );

  always #7 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tlm_valid_o || tlm_err_o || tlm_timeout_o) begin
      mon_o.kind   = {tlm_timeout_o, tlm_err_o, tlm_valid_o};
      mon_o.raw    = tlm_raw_o;
      mon_o.period = tlm_period_o;
      mon_o.cyc    = cyc;
      obs_q.push_back(mon_o);
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("[TB] FAIL watchdog: cycle budget exhausted, got cyc=%0d want <90000", cyc);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [4:0] gcr_of(input logic [3:0] n);
    logic [4:0] q;
    case (n)
      4'h0: q = 5'h19;  4'h1: q = 5'h1B;  4'h2: q = 5'h12;  4'h3: q = 5'h13;
      4'h4: q = 5'h1D;  4'h5: q = 5'h15;  4'h6: q = 5'h16;  4'h7: q = 5'h17;
      4'h8: q = 5'h1A;  4'h9: q = 5'h09;  4'hA: q = 5'h0A;  4'hB: q = 5'h0B;
      4'hC: q = 5'h1E;  4'hD: q = 5'h0D;  4'hE: q = 5'h0E;  default: q = 5'h0F;
    endcase
    return q;
  endfunction

  function automatic logic [20:0] encode(input logic [15:0] v);
    logic [19:0] g;
    logic [20:0] r;
    g = {gcr_of(v[15:12]), gcr_of(v[11:8]), gcr_of(v[7:4]), gcr_of(v[3:0])};
    r = '0;
    for (int i = 19; i >= 0; i--) r[i] = r[i+1] ^ g[i];
    return r;
  endfunction

  function automatic logic [15:0] model_period(input logic [15:0] v);
    int m, e;
    m = int'(v[12:4]);
    e = int'(v[15:13]);
    return 16'(m * (1 << e));
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic arm_pulse(output int a);
    @(posedge clk); #1;
    arm_i = 1'b1;
    a = cyc;
    @(posedge clk); #1;
    arm_i = 1'b0;
  endtask

  // Drive one reply; bclk is the bit length in clocks, jit shifts one real
  // edge in the second half of the frame, rst_bit>=0 pulses reset there.
  task automatic send_frame(input logic [15:0] v, input real bclk, input int jit,
                            input int rst_bit, output int c0);
    logic [20:0] r;
    int          bnd[22];
    int          jb;
    logic        lvl;
    r = encode(v);
    for (int k = 0; k < 22; k++) bnd[k] = $rtoi(k * bclk + 0.5);
    jb = -1;
    if (jit != 0)
      for (int k = 10; k < 21; k++)
        if (jb < 0 && r[21-k] != r[20-k]) jb = k;
    if (jb >= 0) bnd[jb] = bnd[jb] + jit;
    c0 = 0;
    for (int t = 0; t < bnd[21]; t++) begin
      @(posedge clk); #1;
      lvl = 1'b1;
      for (int p = 0; p < 21; p++)
        if (t >= bnd[p] && t < bnd[p+1]) lvl = r[20-p];
      rx_i = lvl;
      if (t == 0) c0 = cyc;
      if (rst_bit >= 0 && t == bnd[rst_bit]) wb_rst_i = 1'b1;
      if (rst_bit >= 0 && t == bnd[rst_bit] + 2) wb_rst_i = 1'b0;
    end
    @(posedge clk); #1;
    rx_i = 1'b1;
  endtask

  task automatic wait_obs(input int budget, output bit got);
    for (int i = 0; i < budget && obs_q.size() == 0; i++) @(posedge clk);
    #1;
    got = (obs_q.size() != 0);
  endtask

  task automatic test_reset();
    bit busy_seen;
    wb_rst_i = 1'b1;
    rx_i = 1'b1;
    idle(4);
    wb_rst_i = 1'b0;
    idle(1);
    total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy_o); end
    total++; if (tlm_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", tlm_valid_o); end
    total++; if (tlm_err_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b want 0", tlm_err_o); end
    total++; if (tlm_timeout_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_timeout: got %b want 0", tlm_timeout_o); end
    total++; if (tlm_raw_o !== 16'h0) begin bad++; $display("[TB] FAIL reset_raw: got %h want 0000", tlm_raw_o); end
    total++; if (tlm_period_o !== 16'h0) begin bad++; $display("[TB] FAIL reset_period: got %h want 0000", tlm_period_o); end
    busy_seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      rx_i = (k >= 100);
      busy_seen = busy_seen | busy_o;
    end
    idle(10);
    total++; if (busy_seen !== 1'b0 || obs_q.size() != 0) begin
      bad++; $display("[TB] FAIL unarmed_edge: got busy=%b pulses=%0d want busy=0 pulses=0", busy_seen, obs_q.size());
    end
  endtask

  task automatic test_basic();
    exp_t e; obs_t o; bit got; int a, c0;
    arm_pulse(a);
    idle(START_DLY - 2);
    e.kind = K_VALID; e.raw = 16'h4649; e.period = 16'd400;
    exp_q.push_back(e);
    send_frame(16'h4649, 96.0, 0, -1, c0);
    wait_obs(300, got);
    e = exp_q.pop_front();
    total++;
    if (!got) begin
      bad++; $display("[TB] FAIL basic_pulse: got none want kind=%b", e.kind);
    end else begin
      o = obs_q.pop_front();
      if (o.kind !== e.kind) begin bad++; $display("[TB] FAIL basic_kind: got %b want %b", o.kind, e.kind); end
      total++; if (o.raw !== e.raw) begin bad++; $display("[TB] FAIL basic_raw: got %h want %h", o.raw, e.raw); end
      total++; if (o.period !== e.period) begin bad++; $display("[TB] FAIL basic_period: got %0d want %0d", o.period, e.period); end
      total++; if (o.cyc - c0 != LAT) begin bad++; $display("[TB] FAIL basic_latency: got %0d want %0d", o.cyc - c0, LAT); end
    end
    idle(200);
    total++; if (obs_q.size() != 0 || busy_o !== 1'b0) begin
      bad++; $display("[TB] FAIL basic_single: got pulses=%0d busy=%b want pulses=0 busy=0", obs_q.size(), busy_o);
    end
  endtask

  task automatic test_rate_jitter();
    real rates[4];
    int  jits[4];
    exp_t e; obs_t o; bit got; int a, c0;
    rates = '{96.0 / 1.03, 96.0 / 1.03, 96.0 / 0.97, 96.0 / 0.97};
    jits  = '{10, -10, 10, -10};
    for (int i = 0; i < 4; i++) begin
      arm_pulse(a);
      idle(START_DLY - 2);
      e.kind = K_VALID; e.raw = 16'h4649; e.period = 16'd400;
      exp_q.push_back(e);
      send_frame(16'h4649, rates[i], jits[i], -1, c0);
      wait_obs(300, got);
      e = exp_q.pop_front();
      total++;
      if (!got) begin
        bad++; $display("[TB] FAIL rate%0d_pulse: got none want kind=%b", i, e.kind);
      end else begin
        o = obs_q.pop_front();
        if (o.kind !== e.kind || o.raw !== e.raw) begin
          bad++; $display("[TB] FAIL rate%0d_frame: got kind=%b raw=%h want kind=%b raw=%h", i, o.kind, o.raw, e.kind, e.raw);
        end
      end
      idle(50);
    end
  endtask

  task automatic test_bad_crc();
    exp_t e; obs_t o; bit got; int a, c0;
    arm_pulse(a);
    idle(START_DLY - 2);
    e.kind = K_ERR; e.raw = 16'h4649; e.period = 16'd400;
    exp_q.push_back(e);
    send_frame(16'h4648, 96.0, 0, -1, c0);
    wait_obs(300, got);
    e = exp_q.pop_front();
    total++;
    if (!got) begin
      bad++; $display("[TB] FAIL crc_pulse: got none want kind=%b", e.kind);
    end else begin
      o = obs_q.pop_front();
      if (o.kind !== e.kind) begin bad++; $display("[TB] FAIL crc_kind: got %b want %b", o.kind, e.kind); end
      total++; if (o.raw !== e.raw || o.period !== e.period) begin
        bad++; $display("[TB] FAIL crc_held: got raw=%h period=%0d want raw=%h period=%0d", o.raw, o.period, e.raw, e.period);
      end
      total++; if (o.cyc - c0 != LAT) begin bad++; $display("[TB] FAIL crc_latency: got %0d want %0d", o.cyc - c0, LAT); end
    end
    idle(50);
  endtask

  task automatic test_timeout();
    exp_t e; obs_t o; bit got; int a, seen; logic busy_at, busy_after;
    arm_pulse(a);
    e.kind = K_TO; e.raw = 16'h4649; e.period = 16'd400;
    exp_q.push_back(e);
    seen = -1; busy_at = 1'b0; busy_after = 1'b1;
    for (int k = 0; k < TIMEOUT_CLKS + 100 && seen < 0; k++) begin
      @(posedge clk); #1;
      if (tlm_timeout_o) begin
        seen = cyc - a;
        busy_at = busy_o;
        @(posedge clk); #1;
        busy_after = busy_o;
      end
    end
    total++; if (seen != TIMEOUT_CLKS) begin bad++; $display("[TB] FAIL timeout_cycle: got %0d want %0d", seen, TIMEOUT_CLKS); end
    total++; if (busy_at !== 1'b1 || busy_after !== 1'b0) begin
      bad++; $display("[TB] FAIL timeout_busy: got %b->%b want 1->0", busy_at, busy_after);
    end
    idle(IDLE_110US - (cyc - a));
    wait_obs(10, got);
    e = exp_q.pop_front();
    total++;
    if (!got) begin
      bad++; $display("[TB] FAIL timeout_pulse: got none want kind=%b", e.kind);
    end else begin
      o = obs_q.pop_front();
      if (o.kind !== e.kind || obs_q.size() != 0) begin
        bad++; $display("[TB] FAIL timeout_kind: got %b extra=%0d want %b extra=0", o.kind, obs_q.size(), e.kind);
      end
    end
  endtask

  task automatic test_echo_blank();
    exp_t e; obs_t o; bit got; int a, c0;
    arm_pulse(a);
    idle(ECHO_DLY - 2);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      rx_i = 1'b0;
    end
    @(posedge clk); #1;
    rx_i = 1'b1;
    idle(START_DLY - ECHO_DLY - 21);
    e.kind = K_VALID; e.raw = 16'h123F; e.period = model_period(16'h123F);
    exp_q.push_back(e);
    send_frame(16'h123F, 96.0, 0, -1, c0);
    wait_obs(300, got);
    e = exp_q.pop_front();
    total++;
    if (!got) begin
      bad++; $display("[TB] FAIL echo_pulse: got none want kind=%b", e.kind);
    end else begin
      o = obs_q.pop_front();
      if (o.kind !== e.kind || o.raw !== e.raw) begin
        bad++; $display("[TB] FAIL echo_frame: got kind=%b raw=%h want kind=%b raw=%h", o.kind, o.raw, e.kind, e.raw);
      end
      total++; if (o.period !== e.period) begin bad++; $display("[TB] FAIL echo_period: got %0d want %0d", o.period, e.period); end
      total++; if (o.cyc - c0 != LAT) begin bad++; $display("[TB] FAIL echo_latency: got %0d want %0d", o.cyc - c0, LAT); end
    end
    idle(50);
  endtask

  task automatic test_reset_midframe();
    exp_t e; obs_t o; bit got; int a, c0;
    arm_pulse(a);
    idle(START_DLY - 2);
    send_frame(16'h4649, 96.0, 0, 10, c0);
    idle(100);
    total++; if (obs_q.size() != 0) begin bad++; $display("[TB] FAIL midrst_pulses: got %0d want 0", obs_q.size()); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy: got %b want 0", busy_o); end
    total++; if (tlm_raw_o !== 16'h0 || tlm_period_o !== 16'h0) begin
      bad++; $display("[TB] FAIL midrst_outputs: got raw=%h period=%h want 0000/0000", tlm_raw_o, tlm_period_o);
    end
    while (obs_q.size() != 0) o = obs_q.pop_front();
    arm_pulse(a);
    idle(START_DLY - 2);
    e.kind = K_VALID; e.raw = 16'h4649; e.period = 16'd400;
    exp_q.push_back(e);
    send_frame(16'h4649, 96.0, 0, -1, c0);
    wait_obs(300, got);
    e = exp_q.pop_front();
    total++;
    if (!got) begin
      bad++; $display("[TB] FAIL midrst_next_pulse: got none want kind=%b", e.kind);
    end else begin
      o = obs_q.pop_front();
      if (o.kind !== e.kind || o.raw !== e.raw || o.period !== e.period) begin
        bad++; $display("[TB] FAIL midrst_next: got kind=%b raw=%h period=%0d want kind=%b raw=%h period=%0d",
                        o.kind, o.raw, o.period, e.kind, e.raw, e.period);
      end
    end
    idle(50);
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_basic();
    test_rate_jitter();
    test_bad_crc();
    test_timeout();
    test_echo_blank();
    test_reset_midframe();
    total++; if (exp_q.size() != 0 || obs_q.size() != 0) begin
      bad++; $display("[TB] FAIL leftovers: got exp=%0d obs=%0d want 0/0", exp_q.size(), obs_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dshot_bidir_tlm_rx.md
Name: dshot_bidir_tlm_rx

Overview:
- Single-channel receiver for bidirectional-DSHOT eRPM telemetry, the ESC-to-FC direction of the motor line.
- After the DSHOT transmitter finishes a frame and releases the pad, this block:
  - watches the pad for the ESC's 21-bit GCR reply;
  - recovers bit timing from line edges;
  - decodes the GCR quintets and checks the 4-bit checksum;
  - outputs the eRPM period in microseconds.
- One instance per motor pad, fed from the pad input path. Results go to the Wishbone status registers.

Parameters:
- BIT_CLKS, 96, clocks per telemetry bit (72 MHz / 750 kbit/s for DSHOT600); must be ≥ 8.
- BLANK_CLKS, 1440, clocks after arm_i during which line edges are ignored (transmit echo / turnaround).
- TIMEOUT_CLKS, 7200, clocks after arm_i within which the start edge must arrive; must be > BLANK_CLKS.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  synchronous reset, active high.
- rx_i  in  1  raw pad level (asynchronous); idle high.
- arm_i  in  1  one-cycle pulse from the DSHOT transmitter: frame done, line released.
- busy_o  out  1  high in any state other than IDLE.
- tlm_valid_o  out  1  one-cycle pulse: good frame decoded.
- tlm_raw_o  out  16  decoded 16-bit word {exp[2:0], mant[8:0], crc[3:0]}; held until the next good frame.
- tlm_period_o  out  16  mant << exp, in µs; held with tlm_raw_o.
- tlm_err_o  out  1  one-cycle pulse: invalid GCR quintet or checksum failure.
- tlm_timeout_o  out  1  one-cycle pulse: no start edge within TIMEOUT_CLKS.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, synchronizer flops to 1 (idle-high line).
- Input path:
  - rx_i passes through a 2-FF synchronizer, giving rx_s (2-cycle latency).
  - A third flop gives rx_d; edge = rx_s ^ rx_d.
  - All timing below is relative to rx_s.
- FSM:
  - IDLE: on arm_i, clear the window counter and go to WAIT_START.
  - WAIT_START:
    - Window counter increments each cycle.
    - Edges are ignored while the counter < BLANK_CLKS.
    - At counter ≥ BLANK_CLKS, a falling edge (rx_s=0, rx_d=1) loads phase=0 and bit index=0, then goes to SAMPLE.
    - If the counter reaches TIMEOUT_CLKS-1 with no start edge: pulse tlm_timeout_o, go to IDLE.
    - arm_i here restarts the window (counter cleared).
  - SAMPLE:
    - Phase counter increments each cycle.
    - Any edge reloads phase to 0; this is clock recovery.
    - When phase == BIT_CLKS/2-1, shift rx_s into raw[20:0] (MSB first), set phase=-BIT_CLKS/2 equivalent so the next sample falls one bit later, and increment the index.
    - Simplest implementation: phase counts 0..BIT_CLKS-1, sample at BIT_CLKS/2-1, wrap at BIT_CLKS-1.
    - After the 21st sample, go to DECODE.
    - arm_i is ignored.
    - If an edge-free run exceeds 6 bit periods (invalid GCR run length), abort with a tlm_err_o pulse and go to IDLE.
  - DECODE: one cycle, registers the decode results, goes to DONE.
  - DONE: one cycle, drives tlm_valid_o or tlm_err_o, goes to IDLE.
- Latency: tlm_valid_o/tlm_err_o is asserted exactly 2 cycles after the cycle that captures sample 21.
- Decode:
  - gcr[i] = raw[i+1] ^ raw[i], for i = 0..19.
  - Quintets q3=gcr[19:15] … q0=gcr[4:0] map to nibbles n3..n0:
    - 19→0, 1B→1, 12→2, 13→3, 1D→4, 15→5, 16→6, 17→7
    - 1A→8, 09→9, 0A→A, 0B→B, 1E→C, 0D→D, 0E→E, 0F→F
  - Any other quintet value is an error.
  - v = {n3,n2,n1,n0}.
  - Checksum OK iff n3^n2^n1^n0 == 4'hF.
  - A start sample raw[20] ≠ 0 is an error.
- Period: tlm_period_o = {7'b0, v[12:4]} << v[15:13], 16-bit; the maximum 511<<7 = 65408 cannot overflow.
- On error: tlm_raw_o and tlm_period_o keep their previous values.
- Reset mid-frame: immediate return to IDLE with no pulses.
- A partial frame never updates the outputs.

Test Plan:
- Reset with rx_i=1 → all outputs 0, busy_o=0. A falling edge on rx_i with no arm_i → no activity.
- arm_i, then at 30 µs a 750 kbit/s reply of v=0x4649 (exp=2, mant=100, crc=9) → one tlm_valid_o pulse, tlm_raw_o=0x4649, tlm_period_o=400, no err.
- Same frame with bit rate +3% and −3%, plus one edge jittered ±10 clocks → still decodes to 0x4649 (edge resync).
- Frame for 0x4648 (checksum broken) → tlm_err_o pulse; tlm_raw_o remains 0x4649 from the prior test.
- arm_i and line held high for 110 µs → tlm_timeout_o pulse at cycle arm+TIMEOUT_CLKS, busy_o drops the next cycle.
- Echo edges at 5 µs after arm_i (inside blank) followed by a valid reply → echo ignored, reply decoded. Separately, wb_rst_i asserted at bit 10 of a reply → IDLE, no pulses; the next armed frame decodes correctly.
